// File: rtl/axi_video_pkg.sv
// Shared video datapath types and constants for the DDR pixel packer/unpacker pair.
package axi_video_pkg;

    localparam int unsigned AXI_DATA_W   = 256;
    localparam int unsigned PIX_W        = 32;
    localparam int unsigned PIX_PER_BEAT = 8;
    localparam int unsigned CNT_W        = 12;

    typedef logic [PIX_W-1:0]      pix_t;
    typedef logic [AXI_DATA_W-1:0] axi_word_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    // Position counter step that rolls over to zero after its last value.
    function automatic cnt_t cnt_wrap_inc(input cnt_t cnt, input cnt_t last);
        return (cnt == last) ? '0 : cnt + cnt_t'(1);
    endfunction

endpackage

// File: rtl/axi_video_unpack_256to32_if.sv
// FIFO read port plus pixel stream seen by the 256-to-32 unpacker.
interface axi_video_unpack_256to32_if;
    import axi_video_pkg::*;

    logic      fifo_rd_vld;
    axi_word_t fifo_rd_data;
    logic      fifo_rd_en;

    logic      pix_rdy;
    logic      pix_vld;
    pix_t      pix_data;
    logic      pix_sof;
    logic      pix_sol;
    logic      pix_eol;

    // master: the unpacker itself
    modport master (
        input  fifo_rd_vld, fifo_rd_data, pix_rdy,
        output fifo_rd_en, pix_vld, pix_data, pix_sof, pix_sol, pix_eol
    );

    // slave: FIFO read port and downstream video pipeline
    modport slave (
        output fifo_rd_vld, fifo_rd_data, pix_rdy,
        input  fifo_rd_en, pix_vld, pix_data, pix_sof, pix_sol, pix_eol
    );

endinterface

// File: rtl/axi_video_unpack_256to32.sv
// Pops 256-bit prefetch FIFO words and streams them out as 32-bit pixels with
// frame/line position flags; pad lanes past the end of each line are dropped.
module axi_video_unpack_256to32
    import axi_video_pkg::AXI_DATA_W;
    import axi_video_pkg::CNT_W;
    import axi_video_pkg::axi_word_t;
    import axi_video_pkg::cnt_t;
    import axi_video_pkg::cnt_wrap_inc;
#(
    parameter int unsigned DATA_IN_W = 256,
    parameter int unsigned PIX_W     = 32,
    parameter int unsigned LANES     = 8,
    parameter int unsigned H_ACTIVE  = 1920,
    parameter int unsigned V_ACTIVE  = 1080
) (
    input  logic                       rd_clk,
    input  logic                       rd_rst,
    axi_video_unpack_256to32_if.master bus,
    input  logic                       frame_sync,
    output logic [CNT_W-1:0]           line_cnt
);

    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam cnt_t              X_LAST    = cnt_t'(H_ACTIVE - 1);
    localparam cnt_t              Y_LAST    = cnt_t'(V_ACTIVE - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

    if (DATA_IN_W != PIX_W * LANES) begin : g_err_width
        $error("DATA_IN_W (%0d) must equal PIX_W*LANES (%0d)", DATA_IN_W, PIX_W * LANES);
    end
    if (DATA_IN_W != AXI_DATA_W || PIX_W != 32) begin : g_err_bus
        $error("unpacker bus is fixed at 256-bit words and 32-bit pixels");
    end
    if (LANES == 0 || (LANES & (LANES - 1)) != 0) begin : g_err_lanes
        $error("LANES (%0d) must be a power of 2", LANES);
    end
    if (H_ACTIVE == 0 || H_ACTIVE > 4095) begin : g_err_h
        $error("H_ACTIVE (%0d) out of range 1..4095", H_ACTIVE);
    end
    if (V_ACTIVE == 0 || V_ACTIVE > 4095) begin : g_err_v
        $error("V_ACTIVE (%0d) out of range 1..4095", V_ACTIVE);
    end

    axi_word_t         hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    cnt_t              x_cnt_q, x_cnt_d;
    cnt_t              line_cnt_q, line_cnt_d;

    logic pix_vld;
    logic beat;
    logic x_last;
    logic last_lane;
    logic pop;

    // Control decode
    always_comb begin
        pix_vld   = hold_vld_q & ~frame_sync & ~rd_rst;
        beat      = pix_vld & bus.pix_rdy;
        x_last    = (x_cnt_q == X_LAST);
        last_lane = (lane_q == LANE_LAST) | x_last;
        // A fresh word is pulled either into an empty holder or as the last lane leaves,
        // so consecutive words stream without a bubble.
        pop       = bus.fifo_rd_vld & ~frame_sync & ~rd_rst &
                    (~hold_vld_q | (beat & last_lane));
    end

    // Next-state
    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        lane_d     = lane_q;
        x_cnt_d    = x_cnt_q;
        line_cnt_d = line_cnt_q;

        if (frame_sync) begin
            hold_vld_d = 1'b0;
            lane_d     = '0;
            x_cnt_d    = '0;
            line_cnt_d = '0;
        end else begin
            if (pop) begin
                hold_d     = bus.fifo_rd_data;
                hold_vld_d = 1'b1;
                lane_d     = '0;
            end else if (beat) begin
                if (last_lane) begin
                    hold_vld_d = 1'b0;
                    lane_d     = '0;
                end else begin
                    lane_d = lane_q + LANE_W'(1);
                end
            end

            if (beat) begin
                x_cnt_d = cnt_wrap_inc(x_cnt_q, X_LAST);
                if (x_last) begin
                    line_cnt_d = cnt_wrap_inc(line_cnt_q, Y_LAST);
                end
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            lane_q     <= '0;
            x_cnt_q    <= '0;
            line_cnt_q <= '0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            lane_q     <= lane_d;
            x_cnt_q    <= x_cnt_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    // Outputs; flags are qualified by pix_vld so an idle stream shows all zeros
    always_comb begin
        bus.fifo_rd_en = pop;
        bus.pix_vld    = pix_vld;
        bus.pix_data   = hold_q[PIX_W*int'(lane_q) +: PIX_W];
        bus.pix_sof    = pix_vld & (x_cnt_q == '0) & (line_cnt_q == '0);
        bus.pix_sol    = pix_vld & (x_cnt_q == '0);
        bus.pix_eol    = pix_vld & x_last;
        line_cnt       = line_cnt_q;
    end

endmodule

// File: tb/tb_axi_video_unpack_256to32.sv
// Scoreboard bench for the 256-to-32 unpacker: streaming, underflow, backpressure,
// frame_sync on a 16x2 instance and line-end padding on a 12x2 instance.
module tb_axi_video_unpack_256to32;
    import axi_video_pkg::*;

    typedef struct packed {
        pix_t        data;
        logic        sof;
        logic        sol;
        logic        eol;
        logic [11:0] line;
    } exp_t;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic        fs16   = 1'b0;
    logic        fs12   = 1'b0;
    logic [11:0] line16;
    logic [11:0] line12;

    axi_video_unpack_256to32_if if16 ();
    axi_video_unpack_256to32_if if12 ();

    axi_video_unpack_256to32 #(.H_ACTIVE(16), .V_ACTIVE(2)) dut16 (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .bus        (if16),
        .frame_sync (fs16),
        .line_cnt   (line16)
    );

    axi_video_unpack_256to32 #(.H_ACTIVE(12), .V_ACTIVE(2)) dut12 (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .bus        (if12),
        .frame_sync (fs12),
        .line_cnt   (line12)
    );

    always #5 rd_clk = ~rd_clk;

    axi_word_t q16[$];
    axi_word_t q12[$];
    exp_t      e16[$];
    exp_t      e12[$];
    int        mx[2]   = '{0, 0};
    int        my[2]   = '{0, 0};
    int        hact[2] = '{16, 12};
    int        vact[2] = '{2, 2};

    int n_tests = 0;
    int n_fail  = 0;
    int n_pix12 = 0;

    logic        s_en, s_vld, s_sof, s_sol, s_eol;
    pix_t        s_data;
    logic [11:0] s_line;

    // FIFO model: head word leaves on the edge where the DUT asserts fifo_rd_en
    always @(posedge rd_clk) begin
        if (if16.fifo_rd_en && q16.size() != 0) void'(q16.pop_front());
        if (if12.fifo_rd_en && q12.size() != 0) void'(q12.pop_front());
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic axi_word_t mkword(input int base);
        axi_word_t w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = 32'(base + i);
        return w;
    endfunction

    // Reference pixel order: lanes in sequence, stop after the last pixel of a line
    task automatic add_exp(input int sel, input axi_word_t w);
        exp_t e;
        for (int l = 0; l < 8; l++) begin
            e.data = w[l*32 +: 32];
            e.sof  = (mx[sel] == 0) && (my[sel] == 0);
            e.sol  = (mx[sel] == 0);
            e.eol  = (mx[sel] == hact[sel] - 1);
            e.line = 12'(my[sel]);
            if (sel == 0) e16.push_back(e);
            else          e12.push_back(e);
            if (mx[sel] == hact[sel] - 1) begin
                mx[sel] = 0;
                my[sel] = (my[sel] + 1) % vact[sel];
                break;
            end
            mx[sel]++;
        end
    endtask

    task automatic push16(input int base, input bit with_exp);
        axi_word_t w;
        w = mkword(base);
        q16.push_back(w);
        if (with_exp) add_exp(0, w);
    endtask

    task automatic push12(input int base);
        axi_word_t w;
        w = mkword(base);
        q12.push_back(w);
        add_exp(1, w);
    endtask

    task automatic drive();
        if16.fifo_rd_vld  = (q16.size() != 0);
        if16.fifo_rd_data = (q16.size() != 0) ? q16[0] : '0;
        if12.fifo_rd_vld  = (q12.size() != 0);
        if12.fifo_rd_data = (q12.size() != 0) ? q12[0] : '0;
    endtask

    task automatic monitor();
        exp_t o;
        exp_t e;
        s_en   = if16.fifo_rd_en;
        s_vld  = if16.pix_vld;
        s_data = if16.pix_data;
        s_sof  = if16.pix_sof;
        s_sol  = if16.pix_sol;
        s_eol  = if16.pix_eol;
        s_line = line16;
        if (if16.pix_vld && if16.pix_rdy) begin
            o = '{if16.pix_data, if16.pix_sof, if16.pix_sol, if16.pix_eol, line16};
            if (e16.size() == 0) check("sb16_extra", 64'(e16.size()), 64'd1);
            else begin
                e = e16.pop_front();
                check("pix16", 64'(o), 64'(e));
            end
        end
        if (if12.pix_vld && if12.pix_rdy) begin
            n_pix12++;
            o = '{if12.pix_data, if12.pix_sof, if12.pix_sol, if12.pix_eol, line12};
            if (e12.size() == 0) check("sb12_extra", 64'(e12.size()), 64'd1);
            else begin
                e = e12.pop_front();
                check("pix12", 64'(o), 64'(e));
            end
        end
    endtask

    // One clock: inputs set at posedge+1, outputs sampled at posedge+3
    task automatic step(input logic rdy, input logic fs);
        drive();
        if16.pix_rdy = rdy;
        fs16         = fs;
        if12.pix_rdy = 1'b1;
        #2;
        monitor();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic wait_pix16(input pix_t v);
        bit found;
        found = 1'b0;
        fs16  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (if16.pix_vld && if16.pix_data == v) begin
                found = 1'b1;
                break;
            end
            step(1'b1, 1'b0);
        end
        check($sformatf("wait_pix_%0h", v), 64'(found), 64'd1);
    endtask

    initial begin
        if16.pix_rdy = 1'b1;
        if12.pix_rdy = 1'b1;
        push16(32'h00, 1'b1);
        push16(32'h08, 1'b1);
        drive();
        @(posedge rd_clk);
        #1;

        // Reset with a word waiting: nothing pops, outputs quiet
        repeat (3) begin
            step(1'b1, 1'b0);
            check("rst_en", 64'(s_en), 64'd0);
            check("rst_vld", 64'(s_vld), 64'd0);
            check("rst_data", 64'(s_data), 64'd0);
            check("rst_line", 64'(s_line), 64'd0);
            check("rst_flags", 64'({s_sof, s_sol, s_eol}), 64'd0);
        end
        rd_rst = 1'b0;
        step(1'b1, 1'b0);
        check("first_en", 64'(s_en), 64'd1);
        check("first_vld", 64'(s_vld), 64'd0);

        // Line 0: 16 pixels back to back across the word boundary
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0);
            check($sformatf("stream_vld_%0d", i), 64'(s_vld), 64'd1);
            if (i == 7) check("boundary_en", 64'(s_en), 64'd1);
        end
        check("line_after_l0", 64'(line16), 64'd1);

        // Underflow: FIFO empty for cycles k..k+3 -> pix_vld low k+1..k+4
        push16(32'h10, 1'b1);
        wait_pix16(32'h17);
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            check($sformatf("uf_vld_%0d", i), 64'(s_vld), 64'd0);
        end
        push16(32'h18, 1'b1);
        step(1'b1, 1'b0);
        check("uf_vld_3", 64'(s_vld), 64'd0);
        check("uf_resume_en", 64'(s_en), 64'd1);
        step(1'b1, 1'b0);
        check("uf_resume_vld", 64'(s_vld), 64'd1);

        // Backpressure on lane 7 (x=15) with the next word already waiting
        push16(32'h20, 1'b1);
        wait_pix16(32'h1f);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            check("bp_data", 64'(s_data), 64'h1f);
            check("bp_flags", 64'({s_sof, s_sol, s_eol}), 64'b001);
            check("bp_en", 64'(s_en), 64'd0);
            check("bp_vld", 64'(s_vld), 64'd1);
        end
        step(1'b1, 1'b0);
        check("bp_release_en", 64'(s_en), 64'd1);

        // frame_sync at x=5, y=1 while the next word sits in the FIFO
        push16(32'h28, 1'b1);
        push16(32'h30, 1'b1);
        push16(32'h40, 1'b0);
        wait_pix16(32'h35);
        check("fs_line_before", 64'(line16), 64'd1);
        step(1'b1, 1'b1);
        check("fs_vld", 64'(s_vld), 64'd0);
        check("fs_en", 64'(s_en), 64'd0);
        e16.delete();
        mx[0] = 0;
        my[0] = 0;
        add_exp(0, mkword(32'h40));
        step(1'b1, 1'b0);
        check("fs_reload_en", 64'(s_en), 64'd1);
        step(1'b1, 1'b0);
        check("fs_next_vld", 64'(s_vld), 64'd1);
        check("fs_next_sof", 64'(s_sof), 64'd1);
        check("fs_next_line", 64'(s_line), 64'd0);

        // Padding: H_ACTIVE=12 drops lanes 0x0c..0x0f of the second word
        push12(32'h00);
        push12(32'h08);
        push12(32'h10);

        for (int i = 0; i < 200; i++) begin
            if (e16.size() == 0 && e12.size() == 0) break;
            step(1'b1, 1'b0);
        end
        check("drain", 64'(e16.size() + e12.size()), 64'd0);
        repeat (5) step(1'b1, 1'b0);
        check("tail_vld16", 64'(s_vld), 64'd0);
        check("pad_count", 64'(n_pix12), 64'd20);
        check("pad_line12", 64'(line12), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
